// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8E1 UART transmitter/receiver pair.
//   uart_state_t : frame-level state, used by both halves and exported on the
//                  top-level debug state outputs
//   FRAME_BITS   : start + 8 data + parity + stop
//   DATA_BITS    : payload bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Deserialises 8E1 frames. The line is synchronised by two flops (reset high),
// the start bit is re-checked at half-bit to reject glitches, and every later
// bit is sampled at mid-bit. Frames with a bad stop bit are dropped.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   rx_i        : asynchronous serial input, idle high
//   rx_data     : last good byte in [7:0], [9:8] always zero
//   rx_parity   : 1 when the last accepted frame had a parity mismatch
//   rx_busy     : high from start detection until the stop sample
//   state       : current FSM state (debug)
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_i,
   output logic [9:0]  rx_data,
   output logic        rx_parity,
   output logic        rx_busy,
   output uart_state_t state
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [9:0]    data_q, data_d;
   logic          perr_q, perr_d;
   logic          busy_q, busy_d;
   logic          sync1_q, sync2_q;
   logic          line;
   logic          bit_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      line     = sync2_q;
      bit_done = (cnt_q == BIT_LAST);
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      data_d   = data_q;
      perr_d   = perr_q;
      busy_d   = busy_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!line) begin
               state_d = START;
               busy_d  = 1'b1;
            end
         end
         START: begin
            // Half-bit re-check; from here on samples land mid-bit.
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (line) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = DATA;
                  idx_d   = '0;
               end
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d   = '0;
               shreg_d = {line, shreg_q[7:1]};
               if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
               else                            idx_d   = idx_q + 3'd1;
            end
         end
         PARITY: begin
            if (bit_done) begin
               cnt_d   = '0;
               par_d   = line;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
               if (line) begin
                  data_d = {2'b00, shreg_q};
                  perr_d = par_q ^ (^shreg_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_data   = data_q;
   assign rx_parity = perr_q;
   assign rx_busy   = busy_q;
   assign state     = state_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serialises one byte per launch into an 8E1 frame, LSB first.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   tx_byte     : byte to send, latched on launch
//   tx_start    : frame request (level)
//   tx_o        : registered serial output, idle high
//   tx_busy     : high from launch until the stop bit has been held
//   state       : current FSM state (debug)
//
// Request semantics: tx_start is a level. A frame launches when the FSM can
// accept one (IDLE, or the last cycle of STOP) while tx_start=1 and the armed
// flag is set. Launch clears armed; any cycle with tx_start=0 sets it again, so
// a request held high across a frame produces exactly one frame.
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  tx_byte,
   input  logic        tx_start,
   output logic        tx_o,
   output logic        tx_busy,
   output uart_state_t state
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic          armed_q, armed_d;
   logic          tx_o_q, tx_o_d;
   logic          busy_q, busy_d;
   logic          bit_done;
   logic          launch;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         armed_q <= 1'b1;
         tx_o_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         armed_q <= armed_d;
         tx_o_q  <= tx_o_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      bit_done = (cnt_q == BIT_LAST);
      // The last STOP cycle may relaunch directly, giving gap-free frames.
      launch   = tx_start && armed_q &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_done));
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      tx_o_d   = tx_o_q;
      busy_d   = busy_q;
      armed_d  = launch ? 1'b0 : (armed_q | ~tx_start);

      case (state_q)
         IDLE: cnt_d = '0;
         START: begin
            if (bit_done) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
               tx_o_d  = shreg_q[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d = '0;
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = PARITY;
                  tx_o_d  = par_q;
               end else begin
                  // Shift so the next bit to send is always in shreg[1].
                  idx_d   = idx_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_o_d  = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d = STOP;
               cnt_d   = '0;
               tx_o_d  = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         state_d = START;
         cnt_d   = '0;
         shreg_d = tx_byte;
         par_d   = ^tx_byte;
         tx_o_d  = 1'b0;
         busy_d  = 1'b1;
      end
   end

   assign tx_o    = tx_o_q;
   assign tx_busy = busy_q;
   assign state   = state_q;

endmodule

// File: rtl/uart_txrx.sv
// -----------------------------------------------------------------------------
// uart_txrx
// Full-duplex 8E1 UART: independent transmitter and receiver sharing one clock
// and a fixed clocks-per-bit divider (even, >= 4).
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   tx_data     : byte to send in [7:0]; [9:8] are ignored
//   tx_start    : frame request (level, re-armed by a low cycle)
//   tx_o        : serial line out, idle high
//   tx_busy     : transmitter mid-frame
//   rx_i        : serial line in, idle high
//   rx_data     : last good received byte in [7:0], [9:8] zero
//   rx_parity   : parity error flag of the last accepted frame
//   rx_busy     : receiver mid-frame
//   tx_state    : transmitter FSM state (debug)
//   rx_state    : receiver FSM state (debug)
// -----------------------------------------------------------------------------
module uart_txrx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  tx_data,
   input  logic        tx_start,
   output logic        tx_o,
   output logic        tx_busy,
   input  logic        rx_i,
   output logic [9:0]  rx_data,
   output logic        rx_parity,
   output logic        rx_busy,
   output uart_state_t tx_state,
   output uart_state_t rx_state
);

   // Upper request bits carry no meaning for an 8-bit frame.
   logic unused_tx_hi;
   assign unused_tx_hi = ^tx_data[9:8];

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk      (clk),
      .reset    (reset),
      .tx_byte  (tx_data[7:0]),
      .tx_start (tx_start),
      .tx_o     (tx_o),
      .tx_busy  (tx_busy),
      .state    (tx_state)
   );

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx_i      (rx_i),
      .rx_data   (rx_data),
      .rx_parity (rx_parity),
      .rx_busy   (rx_busy),
      .state     (rx_state)
   );

endmodule

// File: tb/tb_uart_txrx.sv
// -----------------------------------------------------------------------------
// tb_uart_txrx
// Directed bench for uart_txrx with CLKS_PER_BIT = 4. Inputs change and
// outputs are sampled on the falling clock edge. rx_i is either looped back
// from tx_o or driven directly by the bench.
// -----------------------------------------------------------------------------
module tb_uart_txrx;
   import uart_pkg::*;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  tx_data = '0;
   logic        tx_start = 1'b0;
   logic        tx_o, tx_busy;
   logic        rx_i;
   logic [9:0]  rx_data;
   logic        rx_parity, rx_busy;
   uart_state_t tx_state, rx_state;

   logic        loop_en = 1'b1;
   logic        rx_drv = 1'b1;

   int tests_run    = 0;
   int tests_failed = 0;

   assign rx_i = loop_en ? tx_o : rx_drv;

   always #5 clk = ~clk;

   uart_txrx #(.CLKS_PER_BIT(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_o      (tx_o),
      .tx_busy   (tx_busy),
      .rx_i      (rx_i),
      .rx_data   (rx_data),
      .rx_parity (rx_parity),
      .rx_busy   (rx_busy),
      .tx_state  (tx_state),
      .rx_state  (rx_state)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (tx_o !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_o: got %b want 1", tx_o); end
      tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
      tests_run++; if (rx_data !== 10'h000) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
      tests_run++; if (rx_parity !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_parity: got %b want 0", rx_parity); end
      tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
      tests_run++; if (tx_state !== IDLE || rx_state !== IDLE) begin tests_failed++; $display("FAIL reset_states: got tx %0d rx %0d want 0 0", tx_state, rx_state); end
   endtask

   // 0x56 with junk in [9:8]; frame bits (index = time order) 0,0,1,1,0,1,0,1,0,0,1.
   task automatic test_loopback();
      logic [10:0] frame;
      frame = 11'b10010101100;
      @(negedge clk);
      loop_en  = 1'b1;
      tx_data  = 10'h356;
      tx_start = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i < FRAME_BITS * N) begin
            tests_run++; if (tx_o !== frame[i / N]) begin tests_failed++; $display("FAIL loop_bit cyc %0d: got %b want %b", i, tx_o, frame[i / N]); end
            tests_run++; if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL loop_busy cyc %0d: got %b want 1", i, tx_busy); end
         end else begin
            tests_run++; if (tx_busy !== 1'b0 || tx_o !== 1'b1) begin tests_failed++; $display("FAIL loop_single cyc %0d: got busy %b tx_o %b want 0 1", i, tx_busy, tx_o); end
         end
      end
      tx_start = 1'b0;
      tests_run++; if (rx_data !== 10'h056) begin tests_failed++; $display("FAIL loop_rx_data: got %h want 056", rx_data); end
      tests_run++; if (rx_parity !== 1'b0) begin tests_failed++; $display("FAIL loop_rx_parity: got %b want 0", rx_parity); end
      tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL loop_rx_busy: got %b want 0", rx_busy); end
   endtask

   task automatic test_sequence();
      logic [7:0] bytes [4];
      logic       par [4];
      bytes = '{8'h69, 8'h76, 8'h65, 8'h6B};
      par   = '{1'b0, 1'b1, 1'b0, 1'b1};
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         tx_data  = {2'b00, bytes[j]};
         tx_start = 1'b1;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) begin
               tests_run++; if (tx_o !== 1'b0 || tx_busy !== 1'b1) begin tests_failed++; $display("FAIL seq_launch %0d: got tx_o %b busy %b want 0 1", j, tx_o, tx_busy); end
            end
            if (i == 37) begin
               tests_run++; if (tx_o !== par[j]) begin tests_failed++; $display("FAIL seq_parity_bit %0d: got %b want %b", j, tx_o, par[j]); end
            end
            if (i == 47) begin
               tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL seq_one_frame %0d: got busy %b want 0", j, tx_busy); end
            end
         end
         tx_start = 1'b0;
         repeat (5) @(negedge clk);
         tests_run++; if (rx_data !== {2'b00, bytes[j]}) begin tests_failed++; $display("FAIL seq_rx_data %0d: got %h want %h", j, rx_data, {2'b00, bytes[j]}); end
         tests_run++; if (rx_parity !== 1'b0) begin tests_failed++; $display("FAIL seq_rx_parity %0d: got %b want 0", j, rx_parity); end
      end
   endtask

   // A low pulse mid-frame re-arms, so the next frame starts on the stop edge.
   task automatic test_back_to_back();
      @(negedge clk);
      tx_data  = 10'h0A5;
      tx_start = 1'b1;
      for (int i = 0; i < 96; i++) begin
         @(negedge clk);
         if (i == 10) tx_start = 1'b0;
         if (i == 11) tx_start = 1'b1;
         if (i == 20) tx_data = 10'h03C;
         if (i == 50) tx_start = 1'b0;
         if (i == 43) begin
            tests_run++; if (tx_o !== 1'b1 || tx_busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_stop: got tx_o %b busy %b want 1 1", tx_o, tx_busy); end
         end
         if (i == 44) begin
            tests_run++; if (tx_o !== 1'b0 || tx_busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_relaunch: got tx_o %b busy %b want 0 1", tx_o, tx_busy); end
         end
         if (i == 47) begin
            tests_run++; if (rx_data !== 10'h0A5) begin tests_failed++; $display("FAIL b2b_rx_first: got %h want 0a5", rx_data); end
         end
         if (i == 49) begin
            tests_run++; if (tx_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_new_d0: got %b want 0", tx_o); end
         end
         if (i == 88) begin
            tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got busy %b want 0", tx_busy); end
         end
      end
      tests_run++; if (rx_data !== 10'h03C) begin tests_failed++; $display("FAIL b2b_rx_second: got %h want 03c", rx_data); end
      tests_run++; if (rx_parity !== 1'b0) begin tests_failed++; $display("FAIL b2b_rx_parity: got %b want 0", rx_parity); end
   endtask

   // 0x76 with parity bit 0 (correct would be 1).
   task automatic test_parity_error();
      logic [10:0] frame;
      frame = 11'b10011101100;
      @(negedge clk);
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      for (int b = 0; b < FRAME_BITS; b++) begin
         rx_drv = frame[b];
         repeat (N) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (10) @(negedge clk);
      tests_run++; if (rx_data !== 10'h076) begin tests_failed++; $display("FAIL perr_rx_data: got %h want 076", rx_data); end
      tests_run++; if (rx_parity !== 1'b1) begin tests_failed++; $display("FAIL perr_flag: got %b want 1", rx_parity); end
      tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL perr_rx_busy: got %b want 0", rx_busy); end
   endtask

   // One-cycle glitch, then 0x11 with a zero stop bit: neither may update.
   task automatic test_glitch_framing();
      logic [10:0] frame;
      frame = 11'b00000100010;
      @(negedge clk);
      rx_drv = 1'b0;
      @(negedge clk);
      rx_drv = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++; if (rx_busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_seen: got busy %b want 1", rx_busy); end
      repeat (10) @(negedge clk);
      tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
      tests_run++; if (rx_data !== 10'h076 || rx_parity !== 1'b1) begin tests_failed++; $display("FAIL glitch_hold: got %h/%b want 076/1", rx_data, rx_parity); end
      for (int b = 0; b < FRAME_BITS; b++) begin
         rx_drv = frame[b];
         repeat (N) @(negedge clk);
      end
      rx_drv = 1'b1;
      repeat (12) @(negedge clk);
      tests_run++; if (rx_data !== 10'h076) begin tests_failed++; $display("FAIL frame_err_data: got %h want 076", rx_data); end
      tests_run++; if (rx_parity !== 1'b1) begin tests_failed++; $display("FAIL frame_err_parity: got %b want 1", rx_parity); end
      tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL frame_err_busy: got %b want 0", rx_busy); end
      loop_en = 1'b1;
   endtask

   // Reset lands while both halves are in DATA; start stays high through it.
   task automatic test_reset_mid();
      @(negedge clk);
      tx_data  = 10'h05A;
      tx_start = 1'b1;
      repeat (20) @(negedge clk);
      tests_run++; if (tx_state !== DATA || rx_state !== DATA) begin tests_failed++; $display("FAIL mid_in_data: got tx %0d rx %0d want 2 2", tx_state, rx_state); end
      reset   = 1'b1;
      tx_data = 10'h0C3;
      @(negedge clk);
      tests_run++; if (tx_o !== 1'b1 || tx_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_tx_reset: got tx_o %b busy %b want 1 0", tx_o, tx_busy); end
      tests_run++; if (rx_data !== 10'h000 || rx_parity !== 1'b0) begin tests_failed++; $display("FAIL mid_rx_reset: got %h/%b want 000/0", rx_data, rx_parity); end
      tests_run++; if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rx_busy: got %b want 0", rx_busy); end
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 0) begin
            tests_run++; if (tx_o !== 1'b0 || tx_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_relaunch: got tx_o %b busy %b want 0 1", tx_o, tx_busy); end
         end
      end
      tx_start = 1'b0;
      tests_run++; if (rx_data !== 10'h0C3) begin tests_failed++; $display("FAIL mid_rx_after: got %h want 0c3", rx_data); end
      tests_run++; if (rx_parity !== 1'b0) begin tests_failed++; $display("FAIL mid_rx_parity_after: got %b want 0", rx_parity); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_sequence();
      test_back_to_back();
      test_parity_error();
      test_glitch_framing();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

Full-duplex UART serial link block: a transmitter that serialises one byte per start request into an 8E1 frame (start, 8 data, even parity, stop), and an independent receiver that deserialises such frames and flags parity errors. Both halves share one system clock and run from a fixed clocks-per-bit divider. The block sits between a byte-level host interface and the external serial pins. In loopback benches `tx_o` is tied to `rx_i`.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥ 4.
- `clk`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `tx_data`  in  10  byte to send; only [7:0] is transmitted, [9:8] ignored
- `tx_start`  in  1  frame request, level sampled
- `tx_o`  out  1  serial line out; idle high
- `tx_busy`  out  1  transmitter mid-frame
- `rx_i`  in  1  serial line in; idle high
- `rx_data`  out  10  last good byte in [7:0]; [9:8] always 0
- `rx_parity`  out  1  parity error of the last accepted frame (1 = mismatch)
- `rx_busy`  out  1  receiver mid-frame

## Operation
- Frame format: start bit 0, then D0..D7 LSB first, then even parity (^data), then stop bit 1. 11 bits total.
- TX states: IDLE → START → DATA (8 bits, index 0..7) → PARITY → STOP → IDLE.
  - Each state lasts exactly CLKS_PER_BIT cycles, timed by a bit counter that clears on frame launch.
  - Launch condition: IDLE, `tx_start`=1 and armed. Launch latches `tx_data[7:0]`.
  - Armed flag: cleared on launch, set whenever `tx_start` is sampled 0. A start held high across a whole frame therefore launches exactly one frame.
  - A `tx_start` that rises while busy is ignored.
- RX: `rx_i` passes through a 2-flop synchroniser, reset to 1. Receiver states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the synchronised line is 0; the counter clears at this point.
  - START: at half-bit (CLKS_PER_BIT/2 cycles) the line is re-checked. If it is 1, the event is a glitch: return to IDLE with no output change. If it is 0, proceed.
  - DATA, PARITY and STOP are then each sampled every CLKS_PER_BIT cycles, at mid-bit.
  - STOP sample = 1: `rx_data` ← {2'b00, byte}, `rx_parity` ← (received parity ≠ ^byte), go to IDLE.
  - STOP sample = 0 (framing error): discard the frame; `rx_data` and `rx_parity` hold their values; go to IDLE.
- Reset, including mid-frame: both state machines go to IDLE. `tx_o`=1, `tx_busy`=0, armed=1, `rx_data`=0, `rx_parity`=0, `rx_busy`=0, synchroniser=1.
- Simultaneous reset and start: reset wins.

## Timing
- TX launch sampled at edge k: at edge k, `tx_o` ← 0 and `tx_busy` ← 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - After the stop bit, at edge k+11·CLKS_PER_BIT, `tx_busy` ← 0 with `tx_o` = 1.
  - Earliest next launch is that same edge, if armed.
- TX outputs are registered, with no combinational path from inputs.
- RX input latency is 2 cycles (synchroniser).
  - `rx_busy` rises on the edge after the synchronised 0 is seen and falls on the stop-sample edge.
  - `rx_data`/`rx_parity` update on the stop-sample edge, about 10.5·CLKS_PER_BIT + 3 cycles after `tx_o` falls in loopback.
- RX re-arms in IDLE immediately after the stop sample. Back-to-back frames with no idle gap are received.

## Structure
- Package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), FRAME_BITS=11, DATA_BITS=8.
- Sub-modules `uart_tx` and `uart_rx` are natural. Each owns its own bit counter and data-bit index. `uart_txrx` only instantiates and wires them.

## Test plan
- Reset for 5 cycles, then idle with no start → `tx_o`=1, `tx_busy`=0, `rx_data`=0, `rx_parity`=0, `rx_busy`=0.
- Loopback, N=4: `tx_data`=0x56 with start held 50 cycles →
  - `tx_o` bits 0,0,1,1,0,1,0,1,0,0,1, each 4 cycles.
  - Exactly one frame; `rx_data`=0x056, `rx_parity`=0.
- Sequence 0x69, 0x76, 0x65, 0x6B, each with start high 50 cycles then low 5 → four frames with parity bits 0,1,0,1; `rx_data` matches each; `rx_parity`=0.
- Drive `rx_i` directly with 0x76 and a wrong parity bit 0 → `rx_data`=0x076, `rx_parity`=1.
- Inject a 1-cycle low glitch on `rx_i`, then a frame with stop bit 0 → no update either time; `rx_busy` returns to 0.
- Assert reset in the middle of the DATA state of both halves → next edge shows all outputs at reset values; the following frame is sent and received correctly.
